// File: rtl/rggen_address_decoder.sv
// rggen_address_decoder
//   Matches one 32-bit register slot against an APB byte address. The two low
//   address bits are ignored, so any byte offset within the word hits.
// Parameters:
//   ADDRESS_WIDTH  width of the incoming byte address
//   BASE_ADDRESS   byte address of slot 0 (word aligned)
//   INDEX          slot number this instance recognises
// Ports:
//   i_address      byte address under decode
//   o_match        1 when the address falls in slot INDEX
module rggen_address_decoder #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BASE_ADDRESS  = 0,
   parameter int unsigned INDEX         = 0
) (
   input  logic [ADDRESS_WIDTH-1:0] i_address,
   output logic                     o_match
);

   localparam int unsigned WORD_INDEX = (BASE_ADDRESS >> 2) + INDEX;

   logic [31:0] word_address;
   logic        unused_byte_offset;

   // Compare at 32 bits so a slot beyond the address range never aliases.
   assign word_address       = 32'(i_address[ADDRESS_WIDTH-1:2]);
   assign o_match            = (word_address == WORD_INDEX);
   assign unused_byte_offset = ^i_address[1:0];

endmodule

// File: rtl/rggen_apb_bit_field_bridge.sv
// rggen_apb_bit_field_bridge
//   APB slave that fans accesses out to REGISTERS bit-field slots. Every
//   transfer takes one wait state: the access cycle strobes the addressed
//   slot, the following cycle returns pready with captured read data or an
//   error for an unmapped address.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_psel/i_penable/i_pwrite      APB control
//   i_paddr, i_pstrb, i_pwdata     APB address, byte strobes, write data
//   o_pready/o_pslverr/o_prdata    APB response
//   o_bit_field_valid              per-slot access strobe (access cycle only)
//   o_bit_field_read_mask          per-slot read mask, slot n at [n*WIDTH +: WIDTH]
//   o_bit_field_write_mask         per-slot write mask from byte strobes
//   o_bit_field_write_data         per-slot write data
//   i_bit_field_read_data          per-slot read data
module rggen_apb_bit_field_bridge #(
   parameter int unsigned ADDRESS_WIDTH = 8,
   parameter int unsigned BASE_ADDRESS  = 0,
   parameter int unsigned REGISTERS     = 4,
   parameter int unsigned WIDTH         = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_psel,
   input  logic                         i_penable,
   input  logic                         i_pwrite,
   input  logic [ADDRESS_WIDTH-1:0]     i_paddr,
   input  logic [3:0]                   i_pstrb,
   input  logic [31:0]                  i_pwdata,
   output logic                         o_pready,
   output logic                         o_pslverr,
   output logic [31:0]                  o_prdata,
   output logic [REGISTERS-1:0]         o_bit_field_valid,
   output logic [REGISTERS*WIDTH-1:0]   o_bit_field_read_mask,
   output logic [REGISTERS*WIDTH-1:0]   o_bit_field_write_mask,
   output logic [REGISTERS*WIDTH-1:0]   o_bit_field_write_data,
   input  logic [REGISTERS*WIDTH-1:0]   i_bit_field_read_data
);

   localparam logic STATE_IDLE    = 1'b0;
   localparam logic STATE_RESPOND = 1'b1;

   typedef enum logic {
      StIdle    = STATE_IDLE,
      StRespond = STATE_RESPOND
   } state_e;

   state_e             state_q, state_d;
   logic               slverr_q, slverr_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [REGISTERS-1:0] hit;
   logic               access;
   logic [WIDTH-1:0]   strobe_mask;
   logic [WIDTH-1:0]   read_sel;
   logic               unused_inputs;

   for (genvar g = 0; g < REGISTERS; g++) begin : g_decoder
      rggen_address_decoder #(
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .BASE_ADDRESS  (BASE_ADDRESS),
         .INDEX         (g)
      ) u_decoder (
         .i_address (i_paddr),
         .o_match   (hit[g])
      );
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_strobe
      assign strobe_mask[b] = i_pstrb[b/8];
   end

   assign unused_inputs = ^{i_pwdata, i_pstrb};

   // Reset gates the access so bit-field outputs clear asynchronously too.
   assign access            = i_rst_n && i_psel && i_penable && (state_q == StIdle);
   assign o_bit_field_valid = access ? hit : '0;

   always_comb begin
      o_bit_field_read_mask  = '0;
      o_bit_field_write_mask = '0;
      o_bit_field_write_data = '0;
      read_sel               = '0;
      for (int n = 0; n < REGISTERS; n++) begin
         if (o_bit_field_valid[n]) begin
            if (i_pwrite) begin
               o_bit_field_write_mask[n*WIDTH +: WIDTH] = strobe_mask;
               o_bit_field_write_data[n*WIDTH +: WIDTH] = i_pwdata[WIDTH-1:0];
            end else begin
               o_bit_field_read_mask[n*WIDTH +: WIDTH] = '1;
               read_sel                                = i_bit_field_read_data[n*WIDTH +: WIDTH];
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      slverr_d = slverr_q;
      rdata_d  = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (access) begin
               state_d  = StRespond;
               slverr_d = ~|hit;
               rdata_d  = i_pwrite ? 32'd0 : 32'(read_sel);
            end
         end
         StRespond: begin
            // Always one response cycle; psel dropping early changes nothing.
            state_d  = StIdle;
            slverr_d = 1'b0;
            rdata_d  = '0;
         end
         default: begin
            state_d  = StIdle;
            slverr_d = 1'b0;
            rdata_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         slverr_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         slverr_q <= slverr_d;
         rdata_q  <= rdata_d;
      end
   end

   assign o_pready  = (state_q == StRespond);
   assign o_pslverr = o_pready & slverr_q;
   assign o_prdata  = o_pready ? rdata_q : '0;

endmodule

// File: tb/tb_rggen_apb_bit_field_bridge.sv
module tb_rggen_apb_bit_field_bridge;

   localparam int REGS = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [7:0]   paddr = '0;
   logic [3:0]   pstrb = '0;
   logic [31:0]  pwdata = '0;

   logic         pready, pslverr;
   logic [31:0]  prdata;
   logic [3:0]   valid;
   logic [127:0] rmask, wmask, wdata, rdata_in = '0;

   logic         pready8, pslverr8;
   logic [31:0]  prdata8;
   logic [3:0]   valid8;
   logic [31:0]  rmask8, wmask8, wdata8, rdata8_in = '0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   rggen_apb_bit_field_bridge dut (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_psel                 (psel),
      .i_penable              (penable),
      .i_pwrite               (pwrite),
      .i_paddr                (paddr),
      .i_pstrb                (pstrb),
      .i_pwdata               (pwdata),
      .o_pready               (pready),
      .o_pslverr              (pslverr),
      .o_prdata               (prdata),
      .o_bit_field_valid      (valid),
      .o_bit_field_read_mask  (rmask),
      .o_bit_field_write_mask (wmask),
      .o_bit_field_write_data (wdata),
      .i_bit_field_read_data  (rdata_in)
   );

   rggen_apb_bit_field_bridge #(.WIDTH(8)) dut8 (
      .i_clk                  (clk),
      .i_rst_n                (rst_n),
      .i_psel                 (psel),
      .i_penable              (penable),
      .i_pwrite               (pwrite),
      .i_paddr                (paddr),
      .i_pstrb                (pstrb),
      .i_pwdata               (pwdata),
      .o_pready               (pready8),
      .o_pslverr              (pslverr8),
      .o_prdata               (prdata8),
      .o_bit_field_valid      (valid8),
      .o_bit_field_read_mask  (rmask8),
      .o_bit_field_write_mask (wmask8),
      .o_bit_field_write_data (wdata8),
      .i_bit_field_read_data  (rdata8_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register slot for an address, or -1 when unmapped (base address 0).
   function automatic int reg_idx(input logic [7:0] a);
      int w;
      w = int'(a >> 2);
      return (w >= 0 && w < REGS) ? w : -1;
   endfunction

   // Transaction-level model: a pending response with its error flag and data.
   bit          m_busy = 1'b0;
   bit          m_err = 1'b0;
   logic [31:0] m_data = '0;

   always @(posedge clk or negedge rst_n) begin
      int idx;
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_err  <= 1'b0;
         m_data <= '0;
      end else if (m_busy) begin
         m_busy <= 1'b0;
         m_err  <= 1'b0;
         m_data <= '0;
      end else if (psel && penable) begin
         idx = reg_idx(paddr);
         m_busy <= 1'b1;
         m_err  <= (idx < 0);
         if (idx >= 0 && !pwrite) m_data <= rdata_in[idx*32 +: 32];
         else                     m_data <= '0;
      end
   end

   always @(negedge clk) begin
      logic [127:0] ev, er, ew, ed;
      int idx;
      bit acc;
      acc = rst_n && !m_busy && psel && penable;
      idx = reg_idx(paddr);
      ev = '0; er = '0; ew = '0; ed = '0;
      if (acc && idx >= 0) begin
         ev[idx] = 1'b1;
         if (pwrite) begin
            for (int i = 0; i < 32; i++) begin
               ew[idx*32 + i] = pstrb[i/8];
               ed[idx*32 + i] = pwdata[i];
            end
         end else begin
            er[idx*32 +: 32] = '1;
         end
      end
      check("cmp_valid", 128'(valid), ev);
      check("cmp_read_mask", rmask, er);
      check("cmp_write_mask", wmask, ew);
      check("cmp_write_data", wdata, ed);
      check("cmp_pready", 128'(pready), 128'(m_busy));
      check("cmp_pslverr", 128'(pslverr), 128'(m_busy && m_err));
      check("cmp_prdata", 128'(prdata), m_busy ? 128'(m_data) : 128'd0);
   end

   logic [3:0]   c_valid, c_valid_rdy, c_valid8;
   logic [127:0] c_wmask, c_rmask, c_wdata;
   logic [31:0]  c_wmask8, c_wdata8, c_rd, c_rd8;
   logic         c_rdy_acc, c_rdy, c_err;
   int           c_cyc;

   // Called just after a rising edge: setup, access, ready, then release.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pstrb = s; pwdata = d;
      @(posedge clk); #1 penable = 1'b1;
      #2;
      c_valid = valid; c_wmask = wmask; c_rmask = rmask; c_wdata = wdata;
      c_valid8 = valid8; c_wmask8 = wmask8; c_wdata8 = wdata8;
      c_rdy_acc = pready; c_cyc = cyc;
      @(posedge clk); #3;
      c_rdy = pready; c_err = pslverr; c_rd = prdata; c_rd8 = prdata8; c_valid_rdy = valid;
      @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      int first_cyc;
      rdata_in  = {32'hCAFE_0003, 32'h1234_5678, 32'h0BAD_0001, 32'h5555_0000};
      rdata8_in = 32'hAAAA_BBC3;
      #3;
      check("reset_pready", 128'(pready), 128'd0);
      check("reset_prdata", 128'(prdata), 128'd0);
      check("reset_valid", 128'(valid), 128'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(1'b1, 8'h04, 32'h0000_00A5, 4'h1);
      check("w04_valid", 128'(c_valid), 128'h2);
      check("w04_wmask", c_wmask, 128'h0000_0000_0000_0000_0000_00FF_0000_0000);
      check("w04_wdata", c_wdata, 128'h0000_0000_0000_0000_0000_00A5_0000_0000);
      check("w04_rmask", c_rmask, 128'd0);
      check("w04_pready_access", 128'(c_rdy_acc), 128'd0);
      check("w04_pready", 128'(c_rdy), 128'd1);
      check("w04_pslverr", 128'(c_err), 128'd0);
      check("w04_prdata", 128'(c_rd), 128'd0);
      check("w04_valid_one_cycle", 128'(c_valid_rdy), 128'd0);

      xfer(1'b0, 8'h08, 32'h0, 4'h0);
      check("r08_valid", 128'(c_valid), 128'h4);
      check("r08_rmask", c_rmask, 128'h0000_0000_FFFF_FFFF_0000_0000_0000_0000);
      check("r08_wmask", c_wmask, 128'd0);
      check("r08_prdata", 128'(c_rd), 128'h1234_5678);
      check("r08_pslverr", 128'(c_err), 128'd0);

      xfer(1'b0, 8'h0B, 32'h0, 4'h0);
      check("r0b_valid", 128'(c_valid), 128'h4);
      check("r0b_prdata", 128'(c_rd), 128'h1234_5678);

      xfer(1'b0, 8'h10, 32'h0, 4'h0);
      check("r10_valid", 128'(c_valid), 128'd0);
      check("r10_pready", 128'(c_rdy), 128'd1);
      check("r10_pslverr", 128'(c_err), 128'd1);
      check("r10_prdata", 128'(c_rd), 128'd0);

      xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'h0);
      check("w0c_valid", 128'(c_valid), 128'h8);
      check("w0c_wmask", c_wmask, 128'd0);
      check("w0c_wdata", c_wdata, 128'hFFFF_FFFF_0000_0000_0000_0000_0000_0000);
      check("w0c_pready", 128'(c_rdy), 128'd1);

      xfer(1'b1, 8'h04, 32'h1122_3344, 4'b1010);
      check("w04p_wmask", c_wmask, 128'h0000_0000_0000_0000_FF00_FF00_0000_0000);

      xfer(1'b1, 8'h00, 32'hDEAD_BEEF, 4'hF);
      first_cyc = c_cyc;
      check("w8_valid", 128'(c_valid8), 128'h1);
      check("w8_wmask", 128'(c_wmask8), 128'h0000_00FF);
      check("w8_wdata", 128'(c_wdata8), 128'h0000_00EF);
      xfer(1'b0, 8'h00, 32'h0, 4'hF);
      check("b2b_spacing", 128'(c_cyc - first_cyc), 128'd3);
      check("r8_prdata", 128'(c_rd8), 128'h0000_00C3);
      check("r00_prdata", 128'(c_rd), 128'h5555_0000);

      // Setup phase alone does nothing.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pstrb = 4'hF;
      #2 check("setup_valid", 128'(valid), 128'd0);
      @(posedge clk); #3 check("setup_pready", 128'(pready), 128'd0);
      @(posedge clk); #1;

      // Reset during the response cycle aborts the transfer.
      pwrite = 1'b0; paddr = 8'h08; penable = 1'b0;
      @(posedge clk); #1 penable = 1'b1;
      @(posedge clk); #1 check("abort_pready_before", 128'(pready), 128'd1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_pready", 128'(pready), 128'd0);
      check("abort_prdata", 128'(prdata), 128'd0);
      check("abort_valid", 128'(valid), 128'd0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #3 check("abort_no_pready", 128'(pready), 128'd0);
      end

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rggen_apb_bit_field_bridge.md
RGGEN_APB_BIT_FIELD_BRIDGE -- requirements
Module: rggen_apb_bit_field_bridge

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: APB address width in bits.
REQ-002 Parameter BASE_ADDRESS, default 0: byte address of register 0, word aligned.
REQ-003 Parameter REGISTERS, default 4: number of consecutive 32-bit register slots, range 1..16.
REQ-004 Parameter WIDTH, default 32: bit-field width per register, range 1..32.
REQ-005 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port i_psel / i_penable / i_pwrite, input, 1 each: APB select, enable, direction (1 = write).
REQ-008 Port i_paddr, input, ADDRESS_WIDTH: APB byte address.
REQ-009 Port i_pstrb, input, 4: byte write strobes.
REQ-010 Port i_pwdata, input, 32: write data.
REQ-011 Port o_pready / o_pslverr, output, 1 each: transfer complete and error response.
REQ-012 Port o_prdata, output, 32: read data.
REQ-013 Port o_bit_field_valid, output, REGISTERS: per-register access strobe.
REQ-014 Port o_bit_field_read_mask / o_bit_field_write_mask / o_bit_field_write_data, output, REGISTERS*WIDTH each: register n occupies bits [n*WIDTH +: WIDTH].
REQ-015 Port i_bit_field_read_data, input, REGISTERS*WIDTH: same slicing.

Function
REQ-016 The block SHALL have two states: IDLE and RESPOND.
REQ-017 In IDLE with i_psel=1 and i_penable=1, the block SHALL decode the address and move to RESPOND at the next edge.
REQ-018 Hit: i_paddr[ADDRESS_WIDTH-1:2] equals (BASE_ADDRESS>>2)+n for n in 0..REGISTERS-1; i_paddr[1:0] is ignored.
REQ-019 On a hit in that IDLE access cycle, o_bit_field_valid[n] SHALL be 1 combinationally for exactly that one cycle; all other bits 0.
REQ-020 Read hit: read_mask slice n SHALL be all ones; write_mask slice SHALL be 0.
REQ-021 Write hit: write_mask slice n bit i SHALL be i_pstrb[i/8]; write_data slice SHALL be i_pwdata[WIDTH-1:0]; read_mask slice SHALL be 0.
REQ-022 Write with i_pstrb=0 SHALL still pulse valid, with a zero write mask.
REQ-023 Non-selected slices, and all slices outside the valid cycle, SHALL drive 0 on every mask and data output.
REQ-024 Read hit: i_bit_field_read_data slice n SHALL be captured at the edge entering RESPOND; o_prdata SHALL be that value zero-extended to 32 bits.
REQ-025 Miss: no valid bit SHALL assert; RESPOND SHALL return o_pslverr=1 and o_prdata=0.
REQ-026 In RESPOND, o_pready SHALL be 1; otherwise 0.
REQ-027 o_pslverr and o_prdata SHALL be 0 whenever o_pready=0.
REQ-028 RESPOND SHALL always return to IDLE after one cycle, including when i_psel drops early.
REQ-029 Every transfer SHALL therefore take exactly one wait state: access cycle, then ready cycle.
REQ-030 Write responses SHALL have o_prdata=0.
REQ-031 i_psel=1 with i_penable=0 (setup phase) SHALL cause no action.
REQ-032 An access phase arriving while in RESPOND SHALL be ignored; APB ordering guarantees a setup cycle between transfers.

Reset
REQ-033 When i_rst_n=0, the state SHALL be IDLE, o_pready=0, o_pslverr=0, o_prdata=0, and all bit-field outputs 0, asynchronously.
REQ-034 A reset asserted during RESPOND SHALL abort the transfer; no response SHALL complete after reset release.

Structure
REQ-035 State encodings SHALL be localparams inside the module.
REQ-036 Address matching SHALL be implemented in one sub-module, rggen_address_decoder, instantiated once per register slot; it is reusable by other bus bridges.
REQ-037 No shared package SHALL be needed beyond the existing common macro file.

Verification
REQ-038 Write 0x0000_00A5 to 0x04 with pstrb=0x1: valid=0b0010 for one cycle, write_mask slice1=0x0000_00FF, write_data=0xA5, pready on the next cycle, pslverr=0.
REQ-039 Read 0x08 with read_data slice2=0x1234_5678: read_mask slice2=0xFFFF_FFFF, prdata=0x1234_5678 in the ready cycle.
REQ-040 Read 0x10 with REGISTERS=4: no valid pulse, pready=1, pslverr=1, prdata=0.
REQ-041 Back-to-back write then read on register 0 with WIDTH=8 and pstrb=0xF: second transfer valid occurs exactly 3 cycles after the first; prdata upper 24 bits are 0.
REQ-042 Assert i_rst_n=0 during RESPOND: pready drops immediately, all outputs 0, and no pready after release until a new transfer.
REQ-043 Write with pstrb=0 to 0x0C: valid[3]=1, write_mask=0, pready next cycle.
